// File: rtl/fsm_table_loader_if.sv
// fsm_table_loader_if
// Byte-stream handshake feeding the table loader.
//   in_valid : byte offered by the producer
//   in_data  : byte value
//   in_ready : loader can accept; a byte transfers when in_valid & in_ready
//              are both high at a rising clock edge
// Modports: master (byte producer), slave (loader).
interface fsm_table_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fsm_table_loader.sv
// fsm_table_loader
// Receives framed byte streams (0xA5, SEL, CNT, CNT data bytes, CHK) and,
// once the XOR checksum verifies, writes the staged entries into the
// sequencer's transition table (SEL=1) or dispatch table 1/2 (SEL=2/3).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : in_valid / in_data / in_ready byte stream
//   tr_we/tr_addr/tr_data : transition-table write port (registered)
//   d1_we/d2_we/d_addr/d_data : dispatch-table write ports (registered)
//   busy                : state is not IDLE
//   done                : one-cycle pulse after the last committed write
//   err                 : 0 ok, 1 bad select, 2 bad count, 3 checksum fail
module fsm_table_loader #(
  parameter int TRANS_DEPTH = 13,
  parameter int DISP_DEPTH  = 4,
  parameter int CODE_W      = 3,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fsm_table_loader_if.slave  bus,
  output logic               tr_we,
  output logic [3:0]         tr_addr,
  output logic [CODE_W-1:0]  tr_data,
  output logic               d1_we,
  output logic               d2_we,
  output logic [1:0]         d_addr,
  output logic [STATE_W-1:0] d_data,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err
);

  typedef enum logic [2:0] {IDLE, SEL, CNT, DATA, CHK, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [7:0]         chk_q, chk_d;
  logic [1:0]         err_d;
  logic               tr_we_d, d1_we_d, d2_we_d, done_d;
  logic [3:0]         tr_addr_d;
  logic [CODE_W-1:0]  tr_data_d;
  logic [1:0]         d_addr_d;
  logic [STATE_W-1:0] d_data_d;

  logic               accept;
  logic               stage_we;
  logic [STATE_W-1:0] stage_din;
  logic [7:0]         depth;
  logic               wr_go;
  logic [3:0]         wr_idx;

  // Staging buffer holds payload only; it needs no reset because nothing
  // reads an entry before the current frame has written it.
  logic [STATE_W-1:0] stage [TRANS_DEPTH];

  assign bus.in_ready = (state_q != COMMIT);
  assign busy         = (state_q != IDLE);
  assign accept       = bus.in_valid & bus.in_ready;
  assign depth        = (sel_q == 2'd1) ? 8'(TRANS_DEPTH) : 8'(DISP_DEPTH);
  // Transition codes keep only CODE_W bits; the rest of the entry is zero.
  assign stage_din    = (sel_q == 2'd1) ? STATE_W'(bus.in_data[CODE_W-1:0])
                                        : bus.in_data[STATE_W-1:0];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    err_d     = err;
    tr_we_d   = 1'b0;
    d1_we_d   = 1'b0;
    d2_we_d   = 1'b0;
    done_d    = 1'b0;
    tr_addr_d = tr_addr;
    tr_data_d = tr_data;
    d_addr_d  = d_addr;
    d_data_d  = d_data;
    stage_we  = 1'b0;
    wr_go     = 1'b0;
    wr_idx    = idx_q;

    unique case (state_q)
      IDLE: begin
        if (accept && bus.in_data == 8'hA5) begin
          err_d   = 2'd0;
          chk_d   = 8'h00;
          state_d = SEL;
        end
      end
      SEL: begin
        if (accept) begin
          if (bus.in_data >= 8'h01 && bus.in_data <= 8'h03) begin
            sel_d   = bus.in_data[1:0];
            chk_d   = chk_q ^ bus.in_data;
            state_d = CNT;
          end else begin
            err_d   = 2'd1;
            state_d = IDLE;
          end
        end
      end
      CNT: begin
        if (accept) begin
          if (bus.in_data == 8'h00 || bus.in_data > depth) begin
            err_d   = 2'd2;
            state_d = IDLE;
          end else begin
            cnt_d   = bus.in_data[3:0];
            idx_d   = 4'd0;
            chk_d   = chk_q ^ bus.in_data;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          stage_we = 1'b1;
          chk_d    = chk_q ^ bus.in_data;
          idx_d    = idx_q + 4'd1;
          if (idx_q == cnt_q - 4'd1) state_d = CHK;
        end
      end
      CHK: begin
        if (accept) begin
          if (bus.in_data != chk_q) begin
            err_d   = 2'd3;
            state_d = IDLE;
          end else begin
            // Entry 0 is launched on the CHK edge so the first strobe
            // appears in the cycle right after the checksum byte.
            wr_go   = 1'b1;
            wr_idx  = 4'd0;
            idx_d   = 4'd1;
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        // idx_q is the next entry to launch; reaching cnt_q means the
        // last strobe is already on the port.
        if (idx_q == cnt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wr_go = 1'b1;
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_go) begin
      unique case (sel_q)
        2'd1: begin
          tr_we_d   = 1'b1;
          tr_addr_d = wr_idx;
          tr_data_d = stage[wr_idx][CODE_W-1:0];
        end
        2'd2: begin
          d1_we_d  = 1'b1;
          d_addr_d = wr_idx[1:0];
          d_data_d = stage[wr_idx];
        end
        2'd3: begin
          d2_we_d  = 1'b1;
          d_addr_d = wr_idx[1:0];
          d_data_d = stage[wr_idx];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      chk_q   <= 8'h00;
      err     <= 2'd0;
      tr_we   <= 1'b0;
      d1_we   <= 1'b0;
      d2_we   <= 1'b0;
      done    <= 1'b0;
      tr_addr <= 4'd0;
      tr_data <= '0;
      d_addr  <= 2'd0;
      d_data  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      err     <= err_d;
      tr_we   <= tr_we_d;
      d1_we   <= d1_we_d;
      d2_we   <= d2_we_d;
      done    <= done_d;
      tr_addr <= tr_addr_d;
      tr_data <= tr_data_d;
      d_addr  <= d_addr_d;
      d_data  <= d_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (stage_we) stage[idx_q] <= stage_din;
  end

endmodule

// File: tb/tb_fsm_table_loader.sv
module tb_fsm_table_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tr_we, d1_we, d2_we, busy, done;
  logic [3:0] tr_addr;
  logic [2:0] tr_data;
  logic [1:0] d_addr;
  logic [3:0] d_data;
  logic [1:0] err;

  fsm_table_loader_if bus ();

  fsm_table_loader dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .tr_we(tr_we), .tr_addr(tr_addr), .tr_data(tr_data),
    .d1_we(d1_we), .d2_we(d2_we), .d_addr(d_addr), .d_data(d_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Shadow copies of the three tables, built from the write strobes.
  int tr_tab [16];
  int d1_tab [4];
  int d2_tab [4];
  int tr_cnt, d1_cnt, d2_cnt, done_cnt, done_busy, multi_we;

  always @(negedge clk) begin
    if (tr_we) begin tr_tab[tr_addr] = int'(tr_data); tr_cnt++; end
    if (d1_we) begin d1_tab[d_addr] = int'(d_data); d1_cnt++; end
    if (d2_we) begin d2_tab[d_addr] = int'(d_data); d2_cnt++; end
    if (done) begin done_cnt++; if (busy) done_busy++; end
    if (int'(tr_we) + int'(d1_we) + int'(d2_we) > 1) multi_we++;
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] fr [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout observed=ready_low expected=ready_high");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] sel, input logic [7:0] cnt,
                            input bit bad, input bit gap);
    logic [7:0] x;
    x = sel ^ cnt;
    send_byte(8'hA5);
    send_byte(sel);
    send_byte(cnt);
    for (int i = 0; i < int'(cnt); i++) begin
      send_byte(fr[i]);
      x = x ^ fr[i];
      if (gap) begin @(posedge clk); #1; end
    end
    send_byte(bad ? ~x : x);
  endtask

  initial begin
    int stall;
    int dc;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_strobes", {29'd0, tr_we, d1_we, d2_we}, 32'd0);
    check("rst_tr_addr", 32'(tr_addr), 32'd0);
    check("rst_d_addr", 32'(d_addr), 32'd0);
    check("rst_data", {25'd0, tr_data, d_data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Garbage before header is dropped, then a full transition-table frame
    send_byte(8'h11);
    send_byte(8'h22);
    check("garbage_busy", 32'(busy), 32'd0);
    check("garbage_err", 32'(err), 32'd0);
    fr = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd4, 8'd4,
           8'd0, 8'd0, 8'd0};
    send_frame(8'h01, 8'h0D, 1'b0, 1'b0);
    check("tr_first_strobe", 32'(tr_we), 32'd1);
    check("tr_first_addr", 32'(tr_addr), 32'd0);
    check("tr_commit_ready", 32'(bus.in_ready), 32'd0);
    repeat (16) @(posedge clk);
    #1;
    check("tr_strobe_count", tr_cnt, 32'd13);
    check("tr_e0", tr_tab[0], 32'd0);
    check("tr_e3", tr_tab[3], 32'd1);
    check("tr_e4", tr_tab[4], 32'd2);
    check("tr_e5", tr_tab[5], 32'd2);
    check("tr_e9", tr_tab[9], 32'd0);
    check("tr_e10", tr_tab[10], 32'd3);
    check("tr_e11", tr_tab[11], 32'd4);
    check("tr_e12", tr_tab[12], 32'd4);
    check("tr_done_count", done_cnt, 32'd1);
    check("done_with_busy", done_busy, 32'd0);
    check("tr_err", 32'(err), 32'd0);
    check("tr_no_disp", d1_cnt + d2_cnt, 32'd0);

    // Dispatch table 1 frame
    fr = '{8'h04, 8'h05, 8'h06, 8'h06, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
           8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(8'h02, 8'h04, 1'b0, 1'b0);
    check("d1_first_strobe", 32'(d1_we), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("d1_count", d1_cnt, 32'd4);
    check("d1_e0", d1_tab[0], 32'd4);
    check("d1_e1", d1_tab[1], 32'd5);
    check("d1_e2", d1_tab[2], 32'd6);
    check("d1_e3", d1_tab[3], 32'd6);
    check("d1_no_tr", tr_cnt, 32'd13);
    check("d1_no_d2", d2_cnt, 32'd0);
    check("one_strobe_at_a_time", multi_we, 32'd0);

    // Same dispatch frame with a corrupted checksum
    fr = '{8'h07, 8'h07, 8'h07, 8'h07, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
           8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(8'h02, 8'h04, 1'b1, 1'b0);
    check("badchk_err", 32'(err), 32'd3);
    check("badchk_busy", 32'(busy), 32'd0);
    check("badchk_strobe", 32'(d1_we), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("badchk_no_write", d1_cnt, 32'd4);
    check("badchk_table_kept", d1_tab[0], 32'd4);

    // Following valid frame, dispatch table 2, upper nibble discarded
    fr = '{8'h09, 8'h1A, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
           8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(8'h03, 8'h02, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("d2_count", d2_cnt, 32'd2);
    check("d2_e0", d2_tab[0], 32'd9);
    check("d2_e1", d2_tab[1], 32'd10);
    check("d2_err", 32'(err), 32'd0);
    check("d2_done_count", done_cnt, 32'd3);

    // Select and count errors
    send_byte(8'hA5);
    send_byte(8'h07);
    check("bad_sel_err", 32'(err), 32'd1);
    check("bad_sel_busy", 32'(busy), 32'd0);
    send_byte(8'hA5);
    check("header_clears_err", 32'(err), 32'd0);
    send_byte(8'h02);
    send_byte(8'h05);
    check("bad_cnt5_err", 32'(err), 32'd2);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    check("bad_cnt0_err", 32'(err), 32'd2);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h0E);
    check("bad_cnt14_err", 32'(err), 32'd2);
    check("bad_cnt_busy", 32'(busy), 32'd0);

    // Gapped frame, then a header held valid through COMMIT
    fr = '{8'hF3, 8'h05, 8'h12, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
           8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(8'h01, 8'h03, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    stall = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      stall++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("commit_stall_cycles", stall, 32'd3);
    check("b2b_header_taken", 32'(busy), 32'd1);
    send_byte(8'h07);
    check("b2b_abort_err", 32'(err), 32'd1);
    check("gap_e0_masked", tr_tab[0], 32'd3);
    check("gap_e1", tr_tab[1], 32'd5);
    check("gap_e2_masked", tr_tab[2], 32'd2);
    check("gap_e3_kept", tr_tab[3], 32'd1);
    check("gap_strobe_count", tr_cnt, 32'd16);

    // Reset during COMMIT after the second write
    fr = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07,
           8'h07, 8'h07, 8'd0, 8'd0, 8'd0};
    dc = done_cnt;
    send_frame(8'h01, 8'h0D, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("mid_commit_addr1", 32'(tr_addr), 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(tr_we), 32'd0);
    check("async_rst_addr", 32'(tr_addr), 32'd0);
    check("async_rst_data", 32'(tr_data), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(bus.in_ready), 32'd1);
    check("async_rst_err_done", {30'd0, err[1] | err[0], done}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("partial_e0", tr_tab[0], 32'd7);
    check("partial_e1", tr_tab[1], 32'd7);
    check("partial_e2_kept", tr_tab[2], 32'd2);
    check("partial_count", tr_cnt, 32'd18);
    check("partial_no_done", done_cnt, dc);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
